// File: rtl/life_timer_ctrl.sv
// Play sequencer for the ON phase: lives, level countdown, death/respawn and
// end-of-level time bonus, advanced by per-frame ticks.
module life_timer_ctrl #(
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned TIME_INIT       = 400,
    parameter int unsigned FRAMES_PER_TICK = 24,
    parameter int unsigned DEATH_FRAMES    = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       active,
    input  logic       hit,
    input  logic       fell,
    input  logic       level_done,
    output logic [3:0] lives,
    output logic [9:0] time_left,
    output logic       dying,
    output logic       respawn,
    output logic       bonus_tick,
    output logic       level_clear,
    output logic       initGameOver
);

    localparam int unsigned FW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam int unsigned DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    localparam logic [3:0]    LIVES_RST  = 4'(LIVES_INIT);
    localparam logic [9:0]    TIME_RST   = 10'(TIME_INIT);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_TICK - 1);
    localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_DYING,
        S_RESPAWN,
        S_OVER,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    lives_q, lives_d;
    logic [9:0]    time_q, time_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [DW-1:0] death_q, death_d;
    logic          dying_q, dying_d;
    logic          respawn_q, respawn_d;
    logic          bonus_q, bonus_d;
    logic          clear_q, clear_d;
    logic          over_q, over_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            lives_q   <= LIVES_RST;
            time_q    <= TIME_RST;
            frame_q   <= '0;
            death_q   <= '0;
            dying_q   <= 1'b0;
            respawn_q <= 1'b0;
            bonus_q   <= 1'b0;
            clear_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            time_q    <= time_d;
            frame_q   <= frame_d;
            death_q   <= death_d;
            dying_q   <= dying_d;
            respawn_q <= respawn_d;
            bonus_q   <= bonus_d;
            clear_q   <= clear_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        time_d  = time_q;
        frame_d = frame_q;
        death_d = death_q;
        unique case (state_q)
            S_IDLE: begin
                if (active) begin
                    state_d = S_PLAY;
                    time_d  = TIME_RST;
                    frame_d = '0;
                end
            end
            S_PLAY: begin
                // Death outranks level_done and swallows a coincident frame_tick.
                if (active) begin
                    if (hit || fell || (time_q == '0)) begin
                        state_d = S_DYING;
                        lives_d = (lives_q == '0) ? '0 : lives_q - 4'd1;
                        death_d = '0;
                    end else if (level_done) begin
                        state_d = S_DONE;
                    end else if (frame_tick) begin
                        if (frame_q == FRAME_LAST) begin
                            frame_d = '0;
                            time_d  = time_q - 10'd1;
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (death_q == DEATH_LAST) begin
                        if (lives_q == '0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_RESPAWN;
                            time_d  = TIME_RST;
                            frame_d = '0;
                        end
                    end else begin
                        death_d = death_q + DW'(1);
                    end
                end
            end
            S_RESPAWN: begin
                state_d = S_PLAY;
                time_d  = TIME_RST;
                frame_d = '0;
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            S_DONE: begin
                if (frame_tick && (time_q != '0)) begin
                    time_d = time_q - 10'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flags are decoded from next state so they are valid the cycle a state is entered.
    always_comb begin
        dying_d   = (state_d == S_DYING);
        respawn_d = (state_d == S_RESPAWN);
        over_d    = (state_d == S_OVER);
        clear_d   = (state_d == S_DONE) && (time_d == '0);
        bonus_d   = (state_q == S_DONE) && frame_tick && (time_q != '0);
    end

    assign lives        = lives_q;
    assign time_left    = time_q;
    assign dying        = dying_q;
    assign respawn      = respawn_q;
    assign bonus_tick   = bonus_q;
    assign level_clear  = clear_q;
    assign initGameOver = over_q;

endmodule
